compute_cluster_mem: RTL and testbench

COMPUTE_CLUSTER_MEM -- requirements
Module: compute_cluster_mem

---
 rtl/compute_cluster_mem.sv | 145 ++++++++++++++
 tb/tb_compute_cluster_mem.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/compute_cluster_mem.sv
// Sparse dot-product cluster: shared IFM chunk buffer, per-CU filter buffers.
// Define ACC_SATURATE_EN for saturating accumulators (default wraps).
module compute_cluster_mem #(
  parameter int COMPUTE_UNIT_NUM = 4,
  parameter int BUS_SIZE         = 8,
  parameter int WR_DAT_CYC_NUM   = 4,
  parameter int PREFIX_SUM_SIZE  = 4,
  parameter int SRAM_IFM_NUM     = 64,
  parameter int SRAM_FILTER_NUM  = 64,
  parameter int OUTPUT_BUF_NUM   = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ifm_chunk_wr_valid_i,
  input  logic [$clog2(WR_DAT_CYC_NUM)-1:0] ifm_chunk_wr_count_i,
  input  logic ifm_chunk_wr_sel_i,
  input  logic [$clog2(SRAM_IFM_NUM)-1:0] ifm_sram_rd_count_i,
  input  logic ifm_chunk_rd_sel_i,
  input  logic fil_chunk_wr_valid_i,
  input  logic [$clog2(WR_DAT_CYC_NUM)-1:0] fil_chunk_wr_count_i,
  input  logic fil_chunk_wr_sel_i,
  input  logic fil_chunk_rd_sel_i,
  input  logic [$clog2(SRAM_FILTER_NUM)-1:0] fil_sram_rd_count_i,
  input  logic [COMPUTE_UNIT_NUM-1:0] fil_chunk_cu_wr_sel_i,
  input  logic run_valid_i,
  input  logic total_chunk_start_i,
  input  logic [$clog2(WR_DAT_CYC_NUM*BUS_SIZE/PREFIX_SUM_SIZE)-1:0]
               rd_fil_sparsemap_last_i,
  input  logic [$clog2(OUTPUT_BUF_NUM)-1:0] acc_buf_sel_i,
  output logic total_chunk_end_o,
  input  logic [$clog2(COMPUTE_UNIT_NUM)-1:0] com_unit_out_buf_sel_i,
  output logic [32*OUTPUT_BUF_NUM-1:0] out_buf_dat_o
);

  localparam int RD_DAT_CYC_NUM =
    WR_DAT_CYC_NUM * BUS_SIZE / PREFIX_SUM_SIZE;
  localparam int IDX_W = $clog2(RD_DAT_CYC_NUM);
  localparam int WORD_W = 8 * BUS_SIZE;
  localparam int CHUNK_W = WORD_W * WR_DAT_CYC_NUM;
  localparam int SUB_W = 8 * PREFIX_SUM_SIZE;

  typedef enum logic {IDLE, BUSY} state_t;

  // Backing stores; populated by the simulation environment.
  logic [CHUNK_W-1:0] ifm_sram [SRAM_IFM_NUM];
  logic [CHUNK_W-1:0] fil_sram [SRAM_FILTER_NUM];

  logic [WORD_W-1:0] ifm_buf [2][WR_DAT_CYC_NUM];
  logic [WORD_W-1:0] fil_buf [COMPUTE_UNIT_NUM][2][WR_DAT_CYC_NUM];

  logic [WORD_W-1:0] ifm_word;
  logic [WORD_W-1:0] fil_word;
  logic [CHUNK_W-1:0] ifm_flat;
  logic [CHUNK_W-1:0] fil_flat;
  logic signed [7:0] ea;
  logic signed [7:0] eb;
  logic signed [15:0] prod;
  logic signed [31:0] dots [COMPUTE_UNIT_NUM];
  logic signed [31:0] acc [COMPUTE_UNIT_NUM][OUTPUT_BUF_NUM];

  state_t state;
  logic [IDX_W-1:0] idx;

  assign ifm_word = ifm_sram[ifm_sram_rd_count_i]
                    [int'(ifm_chunk_wr_count_i)*WORD_W +: WORD_W];
  assign fil_word = fil_sram[fil_sram_rd_count_i]
                    [int'(fil_chunk_wr_count_i)*WORD_W +: WORD_W];

  always_ff @(posedge clk_i) begin
    if (ifm_chunk_wr_valid_i)
      ifm_buf[ifm_chunk_wr_sel_i][ifm_chunk_wr_count_i] <= ifm_word;
    for (int cu = 0; cu < COMPUTE_UNIT_NUM; cu++)
      if (fil_chunk_wr_valid_i && fil_chunk_cu_wr_sel_i[cu])
        fil_buf[cu][fil_chunk_wr_sel_i][fil_chunk_wr_count_i]
          <= fil_word;
  end

  always_comb begin
    ea = '0;
    eb = '0;
    prod = '0;
    fil_flat = '0;
    for (int w = 0; w < WR_DAT_CYC_NUM; w++)
      ifm_flat[w*WORD_W +: WORD_W] = ifm_buf[ifm_chunk_rd_sel_i][w];
    for (int cu = 0; cu < COMPUTE_UNIT_NUM; cu++) begin
      dots[cu] = '0;
      for (int w = 0; w < WR_DAT_CYC_NUM; w++)
        fil_flat[w*WORD_W +: WORD_W] =
          fil_buf[cu][fil_chunk_rd_sel_i][w];
      for (int i = 0; i < PREFIX_SUM_SIZE; i++) begin
        ea = ifm_flat[int'(idx)*SUB_W + 8*i +: 8];
        eb = fil_flat[int'(idx)*SUB_W + 8*i +: 8];
        prod = ea * eb;
        dots[cu] = dots[cu] + 32'(prod);
      end
    end
  end

  function automatic logic signed [31:0] acc_add(
    input logic signed [31:0] x,
    input logic signed [31:0] y
  );
    logic [32:0] s;
    s = {x[31], x} + {y[31], y};
`ifdef ACC_SATURATE_EN
    if (s[32] != s[31])
      return s[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
`endif
    return s[31:0];
  endfunction

  // Start has priority: a restart edge never accumulates.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state <= IDLE;
      idx <= '0;
      for (int cu = 0; cu < COMPUTE_UNIT_NUM; cu++)
        for (int b = 0; b < OUTPUT_BUF_NUM; b++)
          acc[cu][b] <= '0;
    end else if (run_valid_i) begin
      if (total_chunk_start_i) begin
        state <= BUSY;
        idx <= '0;
      end else if (state == BUSY) begin
        for (int cu = 0; cu < COMPUTE_UNIT_NUM; cu++)
          acc[cu][acc_buf_sel_i] <=
            acc_add(acc[cu][acc_buf_sel_i], dots[cu]);
        if (idx == rd_fil_sparsemap_last_i) begin
          state <= IDLE;
          idx <= '0;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  assign total_chunk_end_o = (state == BUSY) && run_valid_i &&
                             (idx == rd_fil_sparsemap_last_i);

  always_comb
    for (int b = 0; b < OUTPUT_BUF_NUM; b++)
      out_buf_dat_o[b*32 +: 32] = acc[com_unit_out_buf_sel_i][b];

endmodule

// File: tb/tb_compute_cluster_mem.sv
// Directed bench for compute_cluster_mem; honours ACC_SATURATE_EN.
// SRAM contents are preloaded hierarchically at time zero.
module tb_compute_cluster_mem;

  logic clk;
  logic rst;
  logic ifm_wr_valid;
  logic [1:0] ifm_wr_count;
  logic ifm_wr_sel;
  logic [5:0] ifm_sram_cnt;
  logic ifm_rd_sel;
  logic fil_wr_valid;
  logic [1:0] fil_wr_count;
  logic fil_wr_sel;
  logic fil_rd_sel;
  logic [5:0] fil_sram_cnt;
  logic [3:0] cu_mask;
  logic run_valid;
  logic start;
  logic [2:0] last;
  logic [1:0] acc_sel;
  logic end_o;
  logic [1:0] cu_sel;
  logic [127:0] out;

  int checks = 0;
  int errors = 0;
  int n;
  logic [31:0] sat_exp;

  compute_cluster_mem dut (
    .clk_i(clk),
    .rst_i(rst),
    .ifm_chunk_wr_valid_i(ifm_wr_valid),
    .ifm_chunk_wr_count_i(ifm_wr_count),
    .ifm_chunk_wr_sel_i(ifm_wr_sel),
    .ifm_sram_rd_count_i(ifm_sram_cnt),
    .ifm_chunk_rd_sel_i(ifm_rd_sel),
    .fil_chunk_wr_valid_i(fil_wr_valid),
    .fil_chunk_wr_count_i(fil_wr_count),
    .fil_chunk_wr_sel_i(fil_wr_sel),
    .fil_chunk_rd_sel_i(fil_rd_sel),
    .fil_sram_rd_count_i(fil_sram_cnt),
    .fil_chunk_cu_wr_sel_i(cu_mask),
    .run_valid_i(run_valid),
    .total_chunk_start_i(start),
    .rd_fil_sparsemap_last_i(last),
    .acc_buf_sel_i(acc_sel),
    .total_chunk_end_o(end_o),
    .com_unit_out_buf_sel_i(cu_sel),
    .out_buf_dat_o(out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag,
                       input logic [127:0] obs,
                       input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic view(input string tag, input int cu,
                      input logic [127:0] exp);
    cu_sel = cu[1:0];
    #1;
    check(tag, out, exp);
  endtask

  task automatic load_ifm(input logic bank, input int entry);
    for (int w = 0; w < 4; w++) begin
      ifm_wr_valid = 1'b1;
      ifm_wr_count = w[1:0];
      ifm_wr_sel = bank;
      ifm_sram_cnt = entry[5:0];
      tick();
    end
    ifm_wr_valid = 1'b0;
  endtask

  task automatic load_fil(input logic bank, input int entry,
                          input logic [3:0] mask);
    for (int w = 0; w < 4; w++) begin
      fil_wr_valid = 1'b1;
      fil_wr_count = w[1:0];
      fil_wr_sel = bank;
      fil_sram_cnt = entry[5:0];
      cu_mask = mask;
      tick();
    end
    fil_wr_valid = 1'b0;
  endtask

  // One pass; optional run_valid gap and concurrent bank-1 filter load.
  task automatic run_pass(input string tag, input int lst,
                          input int sel, input int pat,
                          input int plen, input bit ld,
                          input int exp_n);
    last = lst[2:0];
    acc_sel = sel[1:0];
    run_valid = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (n = 1; n < 64; n++) begin
      run_valid = !(n >= pat && n < pat + plen);
      fil_wr_valid = ld && n <= 4;
      fil_wr_count = 2'(n - 1);
      fil_wr_sel = 1'b1;
      fil_sram_cnt = 6'd1;
      cu_mask = 4'b0101;
      #1;
      if (end_o) break;
      tick();
    end
    check({tag, "_end_cyc"}, 128'(n), 128'(exp_n));
    tick();
    fil_wr_valid = 1'b0;
    #1;
    check({tag, "_end_low"}, 128'(end_o), 128'd0);
  endtask

  task automatic fast_pass();
    run_valid = 1'b1;
    last = 3'd7;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    rst = 1'b0;
    {ifm_wr_valid, ifm_wr_count, ifm_wr_sel, ifm_sram_cnt} = '0;
    {fil_wr_valid, fil_wr_count, fil_wr_sel, fil_sram_cnt} = '0;
    {ifm_rd_sel, fil_rd_sel, cu_mask, run_valid, start} = '0;
    {last, acc_sel, cu_sel} = '0;
    dut.ifm_sram[0] = {32{8'h01}};
    dut.ifm_sram[2] = {32{8'h7F}};
    dut.ifm_sram[3] = {16{8'h00, 8'h03}};
    dut.fil_sram[0] = {32{8'h01}};
    dut.fil_sram[1] = {32{8'h02}};
    dut.fil_sram[2] = {32{8'h7F}};
    dut.fil_sram[3] = {32{8'hFE}};
    #1;
    check("rst_end", 128'(end_o), 128'd0);
    check("rst_out", out, 128'd0);
    tick();
    tick();
    rst = 1'b1;

    load_ifm(1'b0, 0);
    load_fil(1'b0, 0, 4'hF);
    load_fil(1'b1, 0, 4'hF);

    run_pass("p_last0", 0, 2, 0, 0, 1'b0, 1);
    view("p_last0_cu0", 0, {32'd0, 32'd4, 64'd0});
    view("p_last0_cu3", 3, {32'd0, 32'd4, 64'd0});

    rst = 1'b0;
    #1;
    check("rst2_end", 128'(end_o), 128'd0);
    view("rst2_cu0", 0, 128'd0);
    rst = 1'b1;

    run_pass("p_last7", 7, 2, 0, 0, 1'b0, 8);
    view("p_last7_cu0", 0, {32'd0, 32'd32, 64'd0});

    run_pass("p_bank0", 7, 0, 0, 0, 1'b1, 8);
    view("p_bank0_cu0", 0, {32'd0, 32'd32, 32'd0, 32'd32});
    load_fil(1'b1, 3, 4'h0);
    fil_rd_sel = 1'b1;
    run_pass("p_bank1", 7, 0, 0, 0, 1'b0, 8);
    view("p_bank1_cu0", 0, {32'd0, 32'd32, 32'd0, 32'd96});
    view("p_bank1_cu1", 1, {32'd0, 32'd32, 32'd0, 32'd64});
    view("p_bank1_cu3", 3, {32'd0, 32'd32, 32'd0, 32'd64});

    fil_rd_sel = 1'b0;
    run_pass("p_pause", 7, 3, 3, 3, 1'b0, 11);
    view("p_pause_cu1", 1, {32'd32, 32'd32, 32'd0, 32'd64});

    load_ifm(1'b1, 3);
    load_fil(1'b0, 3, 4'hF);
    ifm_rd_sel = 1'b1;
    run_pass("p_sign", 1, 1, 0, 0, 1'b0, 2);
    view("p_sign_cu2", 2,
         {32'd32, 32'd32, 32'hFFFF_FFE8, 32'd96});

    ifm_rd_sel = 1'b0;
    run_valid = 1'b1;
    last = 3'd7;
    acc_sel = 2'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("abort_end", 128'(end_o), 128'd0);
    view("abort_cu2", 2, 128'd0);
    rst = 1'b1;
    tick();
    tick();
    view("abort_hold", 2, 128'd0);

    load_ifm(1'b0, 2);
    load_fil(1'b0, 2, 4'hF);
    for (int k = 0; k < 4160; k++) fast_pass();
    view("near_max", 0, 128'h7FFA_0800);
`ifdef ACC_SATURATE_EN
    sat_exp = 32'h7FFF_FFFF;
`else
    sat_exp = 32'h8001_E820;
`endif
    fast_pass();
    view("overflow_cu0", 0, 128'(sat_exp));
    view("overflow_cu3", 3, 128'(sat_exp));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
